// File: rtl/bus_rv32_stall_ctrl_pkg.sv
// Shared widths, FSM state type and slow-window address decode for the
// bus_rv32 CPU stall controller.
package bus_rv32_stall_ctrl_pkg;
   localparam int unsigned address_width = 32;
   localparam int unsigned data_width    = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } stall_state_t;

   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
      return ((addr & mask) == base);
   endfunction
endpackage

// File: rtl/rv32_sat_counter.sv
// Saturating event counter: increments stop at all-ones, clear zeroes it,
// and an increment coincident with a clear leaves the count at one.
module rv32_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && clr_i) begin
         cnt_d = W'(1);
      end else if (inc_i) begin
         if (&cnt_q) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end else if (clr_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/bus_rv32_stall_ctrl.sv
// Holds the CPU while a slow peripheral in the stalling window completes an
// access; a watchdog frees the CPU if the peripheral never finishes.
module bus_rv32_stall_ctrl
   import bus_rv32_stall_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = address_width,
   parameter int unsigned DATA_W      = data_width,
   parameter logic [31:0] SLOW_BASE   = 32'h0000_9000,
   parameter logic [31:0] SLOW_MASK   = 32'hFFFF_FF00,
   parameter int unsigned ARM_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned TCNT_W      = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] address_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              we_i,
   input  logic              rd_i,
   input  logic              module_busy_i,
   input  logic              timeout_clr_i,
   output logic              cpu_halt_o,
   output logic              mod_start_o,
   output logic [ADDR_W-1:0] mod_addr_o,
   output logic [DATA_W-1:0] mod_data_o,
   output logic              mod_we_o,
   output logic              timeout_o,
   output logic [TCNT_W-1:0] timeout_cnt_o
);
   localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] ARM_LAST = TMR_W'(ARM_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

   stall_state_t      state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              start_q, start_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              we_q,    we_d;
   logic              tmo_q,   tmo_d;
   logic              hit_s;
   logic              tmo_evt_s;

   assign hit_s = (we_i | rd_i) & addr_hit(32'(address_i), SLOW_BASE, SLOW_MASK);

   // Halt must land in the hit cycle itself, so it is decoded from state and inputs.
   assign cpu_halt_o = ((state_q == IDLE) && hit_s) || (state_q == ARM) || (state_q == BUSY);

   // next-state, capture and watchdog decisions
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      start_d   = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = we_q;
      tmo_evt_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit_s) begin
               state_d = ARM;
               start_d = 1'b1;
               addr_d  = address_i;
               data_d  = data_i;
               we_d    = we_i;
               timer_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         ARM, BUSY: begin
            timer_d = timer_q + TMR_W'(1);
            if ((state_q == ARM) && module_busy_i) begin
               state_d = BUSY;
            end else if ((state_q == ARM) && (timer_q == ARM_LAST)) begin
               state_d = RELEASE;
            end else if ((state_q == BUSY) && !module_busy_i) begin
               state_d = RELEASE;
            end else if (timer_q == TMO_LAST) begin
               tmo_evt_s = 1'b1;
               state_d   = RELEASE;
            end else begin
               state_d = state_q;
            end
         end
         // The CPU still presents the finished access here, so hits are ignored.
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (tmo_evt_s) begin
         tmo_d = 1'b1;
      end else if (timeout_clr_i) begin
         tmo_d = 1'b0;
      end else begin
         tmo_d = tmo_q;
      end
   end

   // state, timer and captured access registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         timer_q <= '0;
         start_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         start_q <= start_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         tmo_q   <= tmo_d;
      end
   end

   rv32_sat_counter #(
      .W (TCNT_W)
   ) u_tmo_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (tmo_evt_s),
      .clr_i   (timeout_clr_i),
      .cnt_o   (timeout_cnt_o)
   );

   assign mod_start_o = start_q;
   assign mod_addr_o  = addr_q;
   assign mod_data_o  = data_q;
   assign mod_we_o    = we_q;
   assign timeout_o   = tmo_q;
endmodule

// File: tb/tb_bus_rv32_stall_ctrl.sv
// Self-checking bench: directed vector table, randomized accesses against a
// transaction-level model, and watchdog/saturation/reset sequences.
module tb_bus_rv32_stall_ctrl;
   localparam int ARM_C  = 2;
   localparam int TMO    = 1024;
   localparam int F_TMO  = 16;
   localparam logic [31:0] WIN_BASE = 32'h0000_9000;
   localparam logic [31:0] WIN_MASK = 32'hFFFF_FF00;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        we, rd, busy, clr;
   logic [31:0] addr, data;
   logic        halt, start, mwe, tmo;
   logic [31:0] maddr, mdata;
   logic [7:0]  tcnt;

   logic        f_we, f_rd, f_busy, f_clr;
   logic [31:0] f_addr, f_data;
   logic        f_halt, f_start, f_mwe, f_tmo;
   logic [31:0] f_maddr, f_mdata;
   logic [7:0]  f_tcnt;

   bus_rv32_stall_ctrl u_dut (
      .clk_i(clk), .reset_i(rst), .address_i(addr), .data_i(data), .we_i(we), .rd_i(rd),
      .module_busy_i(busy), .timeout_clr_i(clr), .cpu_halt_o(halt), .mod_start_o(start),
      .mod_addr_o(maddr), .mod_data_o(mdata), .mod_we_o(mwe), .timeout_o(tmo),
      .timeout_cnt_o(tcnt)
   );

   // Short watchdog instance so counter saturation fits in a short run.
   bus_rv32_stall_ctrl #(.TIMEOUT_CYC(F_TMO)) u_fast (
      .clk_i(clk), .reset_i(rst), .address_i(f_addr), .data_i(f_data), .we_i(f_we), .rd_i(f_rd),
      .module_busy_i(f_busy), .timeout_clr_i(f_clr), .cpu_halt_o(f_halt), .mod_start_o(f_start),
      .mod_addr_o(f_maddr), .mod_data_o(f_mdata), .mod_we_o(f_mwe), .timeout_o(f_tmo),
      .timeout_cnt_o(f_tcnt)
   );

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      logic        we, rd;
      logic [31:0] addr, data;
      logic        busy;
      logic        halt, start;
      logic [31:0] maddr, mdata;
      logic        mwe;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic w, logic r, logic [31:0] a, logic [31:0] d, logic b,
                               logic h, logic s, logic [31:0] ma, logic [31:0] md, logic mw);
      vec_t v;
      v.we = w; v.rd = r; v.addr = a; v.data = d; v.busy = b;
      v.halt = h; v.start = s; v.maddr = ma; v.mdata = md; v.mwe = mw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; rd = 1'b0; addr = 32'h0; data = 32'h0; busy = 1'b0; clr = 1'b0;
   endtask

   task automatic run_table();
      tbl.delete();
      // write 0x9004, busy high rows 2..6
      tbl.push_back(mk(1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b0, 1'b1, 1'b0, 32'h0,    32'h0,    1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b0, 1'b1, 1'b1, 32'h9004, 32'hA5A5, 1'b1));
      for (int i = 2; i <= 6; i++)
         tbl.push_back(mk(1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b1, 1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b1));
      tbl.push_back(mk(1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b0, 1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b1));
      tbl.push_back(mk(1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b0, 1'b0, 1'b0, 32'h9004, 32'hA5A5, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0, 32'h9004, 32'hA5A5, 1'b1));
      // read 0x9010, busy never rises
      tbl.push_back(mk(1'b0, 1'b1, 32'h9010, 32'h5A5A, 1'b0, 1'b1, 1'b0, 32'h9004, 32'hA5A5, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 32'h9010, 32'h5A5A, 1'b0, 1'b1, 1'b1, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h9010, 32'h5A5A, 1'b0, 1'b1, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h9010, 32'h5A5A, 1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      // outside window, no strobe, mask edge
      tbl.push_back(mk(1'b1, 1'b0, 32'h8004, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h8004, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h9004, 32'h7777, 1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 32'h9100, 32'h4321, 1'b0, 1'b0, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      // busy already high at the hit
      tbl.push_back(mk(1'b0, 1'b1, 32'h90FF, 32'h0,    1'b1, 1'b1, 1'b0, 32'h9010, 32'h5A5A, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h90FF, 32'h0,    1'b1, 1'b1, 1'b1, 32'h90FF, 32'h0,    1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h90FF, 32'h0,    1'b0, 1'b1, 1'b0, 32'h90FF, 32'h0,    1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 32'h90FF, 32'h0,    1'b0, 1'b0, 1'b0, 32'h90FF, 32'h0,    1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0, 32'h90FF, 32'h0,    1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         we = tbl[i].we; rd = tbl[i].rd; addr = tbl[i].addr; data = tbl[i].data; busy = tbl[i].busy;
         @(negedge clk);
         chk($sformatf("tbl%0d_halt", i),  32'(halt),  32'(tbl[i].halt));
         chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].start));
         chk($sformatf("tbl%0d_maddr", i), maddr,      tbl[i].maddr);
         chk($sformatf("tbl%0d_mdata", i), mdata,      tbl[i].mdata);
         chk($sformatf("tbl%0d_mwe", i),   32'(mwe),   32'(tbl[i].mwe));
         chk($sformatf("tbl%0d_tmo", i),   32'(tmo),   32'h0);
         cyc();
      end
   endtask

   // Model: ARM watches busy on cycles 1..ARM_C after the hit; if busy is seen
   // the CPU stays halted up to and including the first busy-low cycle, else
   // it is halted through cycle ARM_C. Release is the following cycle.
   task automatic run_random(input int n_txn);
      int r, len, c, last;
      logic [31:0] a, d, na;
      logic w;
      for (int t = 0; t < n_txn; t++) begin
         r   = $urandom_range(0, 3);
         len = $urandom_range(1, 5);
         a   = WIN_BASE | 32'($urandom_range(0, 255));
         d   = $urandom;
         w   = 1'($urandom_range(0, 1));
         c   = -1;
         for (int k = 1; k <= ARM_C; k++)
            if (c < 0 && k >= r && k <= r + len - 1) c = k;
         last = (c < 0) ? ARM_C : r + len;
         for (int cy = 0; cy <= last + 1; cy++) begin
            we = w; rd = !w; addr = a; data = d;
            busy = (cy >= r) && (cy <= r + len - 1);
            @(negedge clk);
            chk("rnd_halt",  32'(halt),  32'(cy <= last));
            chk("rnd_start", 32'(start), 32'(cy == 1));
            if (cy >= 1) begin
               chk("rnd_maddr", maddr,    a);
               chk("rnd_mdata", mdata,    d);
               chk("rnd_mwe",   32'(mwe), 32'(w));
            end
            cyc();
         end
         na = $urandom;
         if ((na & WIN_MASK) == WIN_BASE) na = na ^ 32'h0000_0100;
         we = 1'($urandom_range(0, 1)); rd = !we; addr = na; data = $urandom;
         busy = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("rnd_idle_halt",  32'(halt),  32'h0);
         chk("rnd_idle_start", 32'(start), 32'h0);
         chk("rnd_idle_maddr", maddr,      a);
         chk("rnd_idle_mwe",   32'(mwe),   32'(w));
         chk("rnd_idle_tmo",   32'(tmo),   32'h0);
         cyc();
      end
      idle_inputs();
   endtask

   task automatic run_timeout();
      int  n;
      bit  done;
      we = 1'b1; rd = 1'b0; addr = 32'h9020; data = 32'hDEAD_BEEF; busy = 1'b1;
      n = 0; done = 1'b0;
      for (int i = 0; i < 1100 && !done; i++) begin
         @(negedge clk);
         if (halt) n++;
         else done = 1'b1;
         if (!done) cyc();
      end
      chk("tmo_halt_len", 32'(n),   32'(TMO + 1));
      chk("tmo_flag",     32'(tmo), 32'h1);
      chk("tmo_cnt",      32'(tcnt), 32'h1);
      chk("tmo_maddr",    maddr,    32'h9020);
      cyc();
      idle_inputs();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_flag", 32'(tmo),  32'h0);
      chk("clr_cnt",  32'(tcnt), 32'h0);
      cyc();
   endtask

   task automatic run_reset_busy();
      we = 1'b1; rd = 1'b0; addr = 32'h9040; data = 32'h1111; busy = 1'b1;
      cyc(); cyc(); cyc();
      @(negedge clk);
      chk("rst_pre_halt", 32'(halt), 32'h1);
      #2;
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rst_halt",  32'(halt),  32'h0);
      chk("rst_start", 32'(start), 32'h0);
      chk("rst_maddr", maddr,      32'h0);
      #1;
      rst = 1'b0;
      cyc();
      rd = 1'b1; addr = 32'h9088; data = 32'h2222;
      @(negedge clk);
      chk("post_rst_halt0",  32'(halt),  32'h1);
      chk("post_rst_start0", 32'(start), 32'h0);
      cyc();
      @(negedge clk);
      chk("post_rst_start1", 32'(start), 32'h1);
      chk("post_rst_maddr",  maddr,      32'h9088);
      chk("post_rst_mwe",    32'(mwe),   32'h0);
      cyc();
      @(negedge clk);
      chk("post_rst_halt2", 32'(halt), 32'h1);
      cyc();
      @(negedge clk);
      chk("post_rst_halt3", 32'(halt), 32'h0);
      cyc();
      idle_inputs();
   endtask

   task automatic run_saturate();
      int  n, exp_cnt;
      bit  done;
      f_rd = 1'b0; f_clr = 1'b0; f_data = 32'h0;
      for (int it = 0; it < 300; it++) begin
         f_we = 1'b1; f_addr = 32'h9000; f_busy = 1'b1;
         n = 0; done = 1'b0;
         for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (f_halt) n++;
            else done = 1'b1;
            if (!done) cyc();
         end
         exp_cnt = (it + 1 > 255) ? 255 : it + 1;
         chk("sat_halt_len", 32'(n),      32'(F_TMO + 1));
         chk("sat_cnt",      32'(f_tcnt), 32'(exp_cnt));
         cyc();
         f_we = 1'b0;
         cyc();
      end
      chk("sat_flag", 32'(f_tmo), 32'h1);
      // clear coincident with a timeout event: set wins, count restarts at one
      f_we = 1'b1; f_addr = 32'h9000; f_data = 32'h3333; f_busy = 1'b1;
      cyc();
      @(negedge clk);
      chk("coin_start", 32'(f_start), 32'h1);
      chk("coin_maddr", f_maddr,      32'h9000);
      chk("coin_mdata", f_mdata,      32'h3333);
      chk("coin_mwe",   32'(f_mwe),   32'h1);
      for (int i = 2; i <= F_TMO; i++) cyc();
      f_clr = 1'b1;
      @(negedge clk);
      chk("coin_halt_evt", 32'(f_halt), 32'h1);
      cyc();
      f_clr = 1'b0;
      @(negedge clk);
      chk("coin_halt_rel", 32'(f_halt), 32'h0);
      chk("coin_flag",     32'(f_tmo),  32'h1);
      chk("coin_cnt",      32'(f_tcnt), 32'h1);
      cyc();
      f_we = 1'b0; f_busy = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      f_we = 1'b0; f_rd = 1'b0; f_addr = 32'h0; f_data = 32'h0; f_busy = 1'b0; f_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_halt",  32'(halt),  32'h0);
      chk("reset_start", 32'(start), 32'h0);
      chk("reset_maddr", maddr,      32'h0);
      chk("reset_mdata", mdata,      32'h0);
      chk("reset_mwe",   32'(mwe),   32'h0);
      chk("reset_tmo",   32'(tmo),   32'h0);
      chk("reset_cnt",   32'(tcnt),  32'h0);
      cyc();
      rst = 1'b0;
      run_table();
      run_random(40);
      run_timeout();
      run_reset_busy();
      run_saturate();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
